// File: rtl/stack_unit_pkg.sv
// Purpose : shared constants and types for the hardware data stack.
// Latency : n/a (definitions only).
// Backpressure: n/a (definitions only).
package stack_unit_pkg;

    // Register-file codes through which the stack state is read back.
    localparam logic [7:0] STACK_TOP_REG    = 8'h20;
    localparam logic [7:0] STACK_AMOUNT_REG = 8'h21;

    localparam int DATA_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } stack_state_t;

endpackage

// File: rtl/stack_unit_mem.sv
// Purpose : DEPTH x 32 stack storage, one falling-edge write port, one async read port.
// Latency : write lands on the falling edge; read is combinational.
// Backpressure: none; every write strobe is accepted.
// Ports   : clock, we/waddr/wdata (write), raddr/rdata (read).
module stack_mem
    import stack_unit_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Storage is intentionally not reset; empty reads are masked upstream.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(negedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_unit.sv
// Purpose : hardware data stack with push/pop/replace, sticky error flags and a memory clear sequence.
// Latency : state updates on the falling edge; top/count readable right after that edge.
// Backpressure: none; pushes when full and pops when empty are dropped and flagged, all ops ignored while busy.
// Ports   : clock, init (async active-low), push_flag/push_valid/push_value, pop_flag, clear_req,
//           STACK_TOP, STACK_AMOUNT, stack_full, stack_empty, stack_overflow, stack_underflow, busy.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              init,
    input  logic              push_flag,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop_flag,
    input  logic              clear_req,
    output logic [DATA_W-1:0] STACK_TOP,
    output logic [15:0]       STACK_AMOUNT,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_overflow,
    output logic              stack_underflow,
    output logic              busy
);

    localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    stack_state_t state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic              push, pop;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [AW-1:0]     top_addr;
    logic [DATA_W-1:0] top_rdata;

    assign push = push_flag && push_valid;
    assign pop  = pop_flag;

    // Slot of the current top; when full the low AW bits wrap to 0 and 0-1 gives DEPTH-1.
    assign top_addr = count_q[AW-1:0] - 1'b1;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        mem_we    = 1'b0;
        mem_waddr = count_q[AW-1:0];
        mem_wdata = push_value;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    udf_d   = 1'b0;
                end else if (push && !pop) begin
                    if (count_q < DEPTH_C) begin
                        mem_we  = 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (pop && !push) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        udf_d = 1'b1;
                    end
                end else if (push && pop) begin
                    // Replace the top in place; on an empty stack this degrades to a plain push.
                    mem_we = 1'b1;
                    if (count_q != '0) begin
                        mem_waddr = top_addr;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clock or negedge init) begin
        if (!init) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    stack_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (top_addr),
        .rdata (top_rdata)
    );

    assign STACK_TOP       = (count_q == '0) ? '0 : top_rdata;
    assign STACK_AMOUNT    = 16'(count_q);
    assign stack_full      = (count_q == DEPTH_C);
    assign stack_empty     = (count_q == '0);
    assign stack_overflow  = ovf_q;
    assign stack_underflow = udf_q;
    assign busy            = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

    localparam int DEPTH = 4;

    logic        clock;
    logic        init;
    logic        push_flag, push_valid, pop_flag, clear_req;
    logic [31:0] push_value;
    logic [31:0] STACK_TOP;
    logic [15:0] STACK_AMOUNT;
    logic        stack_full, stack_empty, stack_overflow, stack_underflow, busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a queue holding the stack contents, plus flags.
    logic [31:0] m_q[$];
    bit          m_ovf, m_udf;
    int          m_clr_left;

    stack_unit #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .init            (init),
        .push_flag       (push_flag),
        .push_valid      (push_valid),
        .push_value      (push_value),
        .pop_flag        (pop_flag),
        .clear_req       (clear_req),
        .STACK_TOP       (STACK_TOP),
        .STACK_AMOUNT    (STACK_AMOUNT),
        .stack_full      (stack_full),
        .stack_empty     (stack_empty),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow),
        .busy            (busy)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_clr_left = 0;
    endtask

    task automatic model_edge(input bit pf, input bit pv, input logic [31:0] v,
                              input bit pp, input bit cr);
        bit ps;
        ps = pf && pv;
        if (m_clr_left > 0) begin
            m_clr_left--;
        end else if (cr) begin
            m_q.delete();
            m_ovf = 0;
            m_udf = 0;
            m_clr_left = DEPTH;
        end else if (ps && !pp) begin
            if (m_q.size() < DEPTH) m_q.push_back(v);
            else m_ovf = 1;
        end else if (pp && !ps) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_udf = 1;
        end else if (ps && pp) begin
            if (m_q.size() > 0) m_q[m_q.size()-1] = v;
            else m_q.push_back(v);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_top;
        exp_top = (m_q.size() == 0) ? 32'h0 : m_q[m_q.size()-1];
        check({tag, ".amount"}, {16'h0, STACK_AMOUNT}, m_q.size());
        check({tag, ".top"},    STACK_TOP, exp_top);
        check({tag, ".full"},   {31'h0, stack_full},  {31'h0, m_q.size() == DEPTH});
        check({tag, ".empty"},  {31'h0, stack_empty}, {31'h0, m_q.size() == 0});
        check({tag, ".ovf"},    {31'h0, stack_overflow},  {31'h0, m_ovf});
        check({tag, ".udf"},    {31'h0, stack_underflow}, {31'h0, m_udf});
        check({tag, ".busy"},   {31'h0, busy}, {31'h0, m_clr_left > 0});
    endtask

    // Drive inputs away from the falling edge, let one falling edge happen, then compare.
    task automatic step(input string tag, input bit pf, input bit pv, input logic [31:0] v,
                        input bit pp, input bit cr);
        push_flag  = pf;
        push_valid = pv;
        push_value = v;
        pop_flag   = pp;
        clear_req  = cr;
        @(negedge clock);
        model_edge(pf, pv, v, pp, cr);
        #1;
        check_all(tag);
    endtask

    initial begin
        init = 1'b0;
        push_flag = 0; push_valid = 0; push_value = '0; pop_flag = 0; clear_req = 0;
        model_reset();
        #2;
        check_all("reset");
        #10 init = 1'b1;

        // Three pushes.
        step("push1", 1, 1, 32'h11, 0, 0);
        step("push2", 1, 1, 32'h22, 0, 0);
        step("push3", 1, 1, 32'h33, 0, 0);
        // Fill, overflow, then replace while full.
        step("push4", 1, 1, 32'h44, 0, 0);
        step("ovf",   1, 1, 32'h55, 0, 0);
        step("repl_full", 1, 1, 32'h66, 1, 0);
        // Drain to empty, underflow, then push+pop on empty.
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 32'h0, 1, 0);
        step("udf", 0, 0, 32'h0, 1, 0);
        step("pp_empty", 1, 1, 32'h77, 1, 0);
        // push_flag without write-back strobe.
        for (int i = 0; i < 3; i++) step("novalid", 1, 0, 32'hdead, 0, 0);
        // Clear from count=3, with pushes offered during CLEAR.
        step("pre_clr1", 1, 1, 32'h81, 0, 0);
        step("pre_clr2", 1, 1, 32'h82, 0, 0);
        step("clr_acc", 1, 1, 32'hbad0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step("clr_busy", 1, 1, 32'hbad1, 1, 1);
        step("post_clr", 1, 1, 32'h9, 0, 0);

        // Asynchronous reset in the middle of CLEAR.
        step("clr2_acc", 0, 0, 32'h0, 0, 1);
        step("clr2_run", 0, 0, 32'h0, 0, 0);
        #2;
        init = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #3 init = 1'b1;
        step("after_rst", 1, 1, 32'ha5, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit pf, pv, pp, cr;
            pf = ($urandom_range(0, 99) < 55);
            pv = ($urandom_range(0, 99) < 85);
            pp = ($urandom_range(0, 99) < 40);
            cr = ($urandom_range(0, 99) < 3);
            step("rand", pf, pv, $urandom, pp, cr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
